lbp_gray_host: RTL

- Host-side responder for the LBP engine's two memory-style interfaces: serves the gray-image read port and captures the LBP result write port.
- Holds a 128x128 8-bit gray image loaded over a simple streaming port. Raises gray_ready once loaded, then answers gray_addr with gray_data in the same cycle.
- Stores every lbp_valid write into a result memory that the testbench/SoC reads back after finish.

---
 rtl/lbp_gray_host.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lbp_gray_host.sv
// lbp_gray_host: serves gray-image reads and captures LBP result writes.
// Optional protocol checker enabled by defining LBP_HOST_CHECK_EN.
module lbp_gray_host #(
  parameter int IMG_W = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   wr_count,
  output logic          done,
  output logic          err
);
  localparam int HW   = AW / 2;
  localparam int NPIX = IMG_W * IMG_W;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] load_ptr_q, load_ptr_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic          load_acc, lbp_acc;

  logic [DW-1:0] gray_mem [NPIX];
  logic [DW-1:0] lbp_mem  [NPIX];

  assign load_acc = (state_q == LOAD) && load_valid;
  assign lbp_acc  = (state_q == SERVE) && lbp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      load_ptr_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (load_acc && load_ptr_q == LAST) state_d = SERVE;
      SERVE:   if (finish) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  // Pointer wraps to 0 naturally after the last pixel.
  always_comb begin
    load_ptr_d = load_ptr_q;
    if (load_acc) load_ptr_d = load_ptr_q + AW'(1);
    wr_count_d = wr_count_q;
    if (lbp_acc && !(&wr_count_q))
      wr_count_d = wr_count_q + (AW+1)'(1);
  end

  always_comb begin
    load_ready = (state_q == LOAD);
    gray_ready = (state_q != LOAD);
    done       = (state_q == DONE);
    gray_data  = gray_ready ? gray_mem[gray_addr] : '0;
    rd_data    = lbp_mem[rd_addr];
    wr_count   = wr_count_q;
  end

  always_ff @(posedge clk) begin
    if (load_acc) gray_mem[load_ptr_q] <= load_data;
  end

  // Loading clears the result image so untouched border pixels read 0.
  always_ff @(posedge clk) begin
    if (load_acc)
      lbp_mem[load_ptr_q] <= '0;
    else if (lbp_acc)
      lbp_mem[lbp_addr] <= lbp_data;
  end

`ifdef LBP_HOST_CHECK_EN
  localparam logic [AW:0] NINT = (AW+1)'((IMG_W - 2) * (IMG_W - 2));
  logic [HW-1:0] row, col;
  logic          border, bad, err_q;

  assign row    = lbp_addr[AW-1:HW];
  assign col    = lbp_addr[HW-1:0];
  assign border = (row == '0) || (row == HW'(IMG_W - 1))
               || (col == '0) || (col == HW'(IMG_W - 1));
  assign bad    = (lbp_valid && (border || state_q != SERVE))
               || (gray_req && !gray_ready)
               || (finish && wr_count_d != NINT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | bad;
  end

  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = gray_req;
  assign err        = 1'b0;
`endif

endmodule
